// File: rtl/rv_wb_pkg.sv
// Shared write-back encodings: result-source selects, load funct3 codes and
// default datapath widths used by the register-file slice.
package rv_wb_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int AW_DEFAULT   = 5;
   localparam int NREG_DEFAULT = 32;

   // Result source select carried in the MEM/WB control fields
   localparam logic [2:0] WB_SEL_ALU   = 3'b000;
   localparam logic [2:0] WB_SEL_LOAD  = 3'b001;
   localparam logic [2:0] WB_SEL_PC4   = 3'b010;
   localparam logic [2:0] WB_SEL_IMM   = 3'b011;
   localparam logic [2:0] WB_SEL_PCIMM = 3'b100;

   // Load funct3 codes
   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

endpackage

// File: rtl/wb_regfile_load_ext.sv
// Combinational load formatter: picks the byte or halfword addressed by the
// low address bits out of the aligned memory word and sign/zero extends it.
module load_ext
   import rv_wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] i_word,
   input  logic [1:0]      i_off,
   input  logic [2:0]      i_funct3,
   output logic [XLEN-1:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane extraction; a misaligned halfword only looks at off[1], no trap here
   always_comb begin
      w_byte = i_word[7:0];
      case (i_off)
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         2'd3:    w_byte = i_word[31:24];
         default: w_byte = i_word[7:0];
      endcase
      w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
   end

   // Width and sign handling by funct3; unknown codes yield zero
   always_comb begin
      o_data = '0;
      case (i_funct3)
         LD_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
         LD_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
         LD_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
         LD_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
         LD_LW:   o_data = i_word;
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and integer register file: selects the architectural
// result, writes it into the 32-entry file and serves the two decode read
// ports with same-cycle write-to-read bypass.
module wb_regfile
   import rv_wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT,
   parameter int NREG = NREG_DEFAULT,
   parameter int AW   = AW_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_RegWrite,
   input  logic [2:0]      i_wb_sel,
   input  logic [2:0]      i_ld_funct3,
   input  logic [XLEN-1:0] i_pc4,
   input  logic [XLEN-1:0] i_imme,
   input  logic [XLEN-1:0] i_pc_imm,
   input  logic [XLEN-1:0] i_aluout,
   input  logic [XLEN-1:0] i_readdata,
   input  logic [AW-1:0]   i_Rd,
   input  logic [AW-1:0]   i_Rs1,
   input  logic [AW-1:0]   i_Rs2,
   output logic [XLEN-1:0] o_rdata1,
   output logic [XLEN-1:0] o_rdata2,
   output logic [XLEN-1:0] o_wb_data
);

   logic [XLEN-1:0] r_regs [NREG];
   logic [XLEN-1:0] w_load;
   logic            w_wr_en;
   logic            w_byp1;
   logic            w_byp2;

   load_ext #(.XLEN(XLEN)) u_load_ext (
      .i_word   (i_readdata),
      .i_off    (i_aluout[1:0]),
      .i_funct3 (i_ld_funct3),
      .o_data   (w_load)
   );

   // Result source mux; reserved select codes produce zero
   always_comb begin
      o_wb_data = '0;
      case (i_wb_sel)
         WB_SEL_ALU:   o_wb_data = i_aluout;
         WB_SEL_LOAD:  o_wb_data = w_load;
         WB_SEL_PC4:   o_wb_data = i_pc4;
         WB_SEL_IMM:   o_wb_data = i_imme;
         WB_SEL_PCIMM: o_wb_data = i_pc_imm;
         default:      o_wb_data = '0;
      endcase
   end

   // A write to x0 is never a real write, so it neither updates nor bypasses
   assign w_wr_en = i_RegWrite && (i_Rd != '0) && rst_n;
   assign w_byp1  = w_wr_en && (i_Rd == i_Rs1);
   assign w_byp2  = w_wr_en && (i_Rd == i_Rs2);

   // Storage: reset clears every entry so no X can ever be read back
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[i_Rd] <= o_wb_data;
      end
   end

   // Read ports: x0 hard-wired to zero, then bypass, then stored value
   always_comb begin
      o_rdata1 = r_regs[i_Rs1];
      o_rdata2 = r_regs[i_Rs2];
      if (i_Rs1 == '0) begin
         o_rdata1 = '0;
      end else if (w_byp1) begin
         o_rdata1 = o_wb_data;
      end
      if (i_Rs2 == '0) begin
         o_rdata2 = '0;
      end else if (w_byp2) begin
         o_rdata2 = o_wb_data;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: vector table plus hand sequences for reset, x0 and
// reset-during-write, checked through an expected-value queue.
module tb_wb_regfile;

   logic        clk;
   logic        rst_n;
   logic        i_RegWrite;
   logic [2:0]  i_wb_sel;
   logic [2:0]  i_ld_funct3;
   logic [31:0] i_pc4;
   logic [31:0] i_imme;
   logic [31:0] i_pc_imm;
   logic [31:0] i_aluout;
   logic [31:0] i_readdata;
   logic [4:0]  i_Rd;
   logic [4:0]  i_Rs1;
   logic [4:0]  i_Rs2;
   logic [31:0] o_rdata1;
   logic [31:0] o_rdata2;
   logic [31:0] o_wb_data;

   wb_regfile dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_RegWrite  (i_RegWrite),
      .i_wb_sel    (i_wb_sel),
      .i_ld_funct3 (i_ld_funct3),
      .i_pc4       (i_pc4),
      .i_imme      (i_imme),
      .i_pc_imm    (i_pc_imm),
      .i_aluout    (i_aluout),
      .i_readdata  (i_readdata),
      .i_Rd        (i_Rd),
      .i_Rs1       (i_Rs1),
      .i_Rs2       (i_Rs2),
      .o_rdata1    (o_rdata1),
      .o_rdata2    (o_rdata2),
      .o_wb_data   (o_wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  sel;
      logic [2:0]  f3;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic [31:0] exp_wb;
   } vec_t;

   typedef struct {
      string       nm;
      logic [31:0] exp;
   } sb_t;

   vec_t        vecs [13];
   sb_t         sb_q [$];
   logic [31:0] model [32];
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic expect_val(input string nm, input logic [31:0] exp);
      sb_t it;
      it.nm  = nm;
      it.exp = exp;
      sb_q.push_back(it);
   endtask

   task automatic chk(input logic [31:0] act);
      sb_t it;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty: got %h, nothing expected", act);
      end else begin
         it = sb_q.pop_front();
         if (act !== it.exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", it.nm, act, it.exp);
         end
      end
   endtask

   function automatic vec_t mk(input logic [2:0] sel, input logic [2:0] f3,
                               input logic [31:0] alu, input logic [4:0] rd,
                               input logic [31:0] exp_wb);
      vec_t v;
      v.sel = sel; v.f3 = f3; v.alu = alu; v.rd = rd; v.exp_wb = exp_wb;
      return v;
   endfunction

   task automatic drive(input logic we, input logic [2:0] sel, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
      i_RegWrite  = we;
      i_wb_sel    = sel;
      i_ld_funct3 = f3;
      i_aluout    = alu;
      i_Rd        = rd;
      i_Rs1       = rs1;
      i_Rs2       = rs2;
   endtask

   initial begin
      vecs[0]  = mk(3'b001, 3'b000, 32'h0000_0003, 5'd10, 32'hFFFF_FF80); // LB off3
      vecs[1]  = mk(3'b001, 3'b100, 32'h0000_0001, 5'd11, 32'h0000_007F); // LBU off1
      vecs[2]  = mk(3'b001, 3'b001, 32'h0000_0002, 5'd12, 32'hFFFF_80FF); // LH off2
      vecs[3]  = mk(3'b001, 3'b101, 32'h0000_0000, 5'd13, 32'h0000_7F01); // LHU off0
      vecs[4]  = mk(3'b001, 3'b010, 32'h0000_0002, 5'd14, 32'h80FF_7F01); // LW
      vecs[5]  = mk(3'b011, 3'b000, 32'h0000_0000, 5'd15, 32'hABCD_E000); // LUI
      vecs[6]  = mk(3'b100, 3'b000, 32'h0000_0000, 5'd16, 32'h0000_1010); // AUIPC
      vecs[7]  = mk(3'b111, 3'b000, 32'h1111_1111, 5'd17, 32'h0000_0000); // reserved
      vecs[8]  = mk(3'b000, 3'b000, 32'h1234_5678, 5'd3,  32'h1234_5678); // ALU
      vecs[9]  = mk(3'b010, 3'b000, 32'h0000_0000, 5'd7,  32'h0000_0104); // pc+4
      vecs[10] = mk(3'b001, 3'b011, 32'h0000_0000, 5'd18, 32'h0000_0000); // bad funct3
      vecs[11] = mk(3'b001, 3'b001, 32'h0000_0003, 5'd19, 32'hFFFF_80FF); // LH misaligned
      vecs[12] = mk(3'b001, 3'b000, 32'h0000_0002, 5'd20, 32'hFFFF_FFFF); // LB off2

      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      i_pc4      = 32'h0000_0104;
      i_imme     = 32'hABCD_E000;
      i_pc_imm   = 32'h0000_1010;
      i_readdata = 32'h80FF_7F01;
      rst_n      = 1'b0;
      drive(1'b0, 3'b000, 3'b000, 32'h0, 5'd0, 5'd0, 5'd0);

      // Reset: write attempt and bypass both suppressed
      @(posedge clk); #1;
      drive(1'b1, 3'b000, 3'b000, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
      #3;
      expect_val("rst_rdata1", 32'h0);        chk(o_rdata1);
      expect_val("rst_rdata2", 32'h0);        chk(o_rdata2);
      expect_val("rst_wb_data", 32'hDEAD_BEEF); chk(o_wb_data);
      @(posedge clk); #1;
      expect_val("rst_after_edge", 32'h0);    chk(o_rdata1);
      rst_n = 1'b1;
      drive(1'b0, 3'b000, 3'b000, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd0);
      #3;
      expect_val("post_rst_x5", 32'h0);       chk(o_rdata1);

      // Vector table: Rs1 hits the bypass, Rs2 reads the previous write from storage
      for (int i = 0; i < 13; i++) begin
         logic [4:0] prev;
         prev = (i == 0) ? 5'd5 : vecs[i-1].rd;
         @(posedge clk); #1;
         drive(1'b1, vecs[i].sel, vecs[i].f3, vecs[i].alu, vecs[i].rd, vecs[i].rd, prev);
         expect_val($sformatf("v%0d_wb_data", i), vecs[i].exp_wb);
         expect_val($sformatf("v%0d_bypass1", i), vecs[i].exp_wb);
         expect_val($sformatf("v%0d_stored2_x%0d", i, prev), model[prev]);
         #3;
         chk(o_wb_data);
         chk(o_rdata1);
         chk(o_rdata2);
         @(posedge clk);
         model[vecs[i].rd] = vecs[i].exp_wb;
         #1;
         drive(1'b0, 3'b000, 3'b000, 32'h0, 5'd0, 5'd0, 5'd0);
      end

      // Storage readback of every written register on both ports
      for (int i = 0; i < 13; i++) begin
         @(posedge clk); #1;
         drive(1'b0, 3'b000, 3'b000, 32'h0, vecs[i].rd, vecs[i].rd, vecs[i].rd);
         expect_val($sformatf("rb1_x%0d", vecs[i].rd), model[vecs[i].rd]);
         expect_val($sformatf("rb2_x%0d", vecs[i].rd), model[vecs[i].rd]);
         #3;
         chk(o_rdata1);
         chk(o_rdata2);
      end

      // x0: write attempt ignored, no bypass, reads zero before and after
      @(posedge clk); #1;
      drive(1'b1, 3'b000, 3'b000, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
      #3;
      expect_val("x0_before", 32'h0);         chk(o_rdata1);
      expect_val("x0_wb_data", 32'hFFFF_FFFF); chk(o_wb_data);
      @(posedge clk); #1;
      drive(1'b0, 3'b000, 3'b000, 32'h0, 5'd0, 5'd0, 5'd0);
      #3;
      expect_val("x0_after", 32'h0);          chk(o_rdata1);

      // Reset asserted during a write: bypass drops, write lost, file cleared
      @(posedge clk); #1;
      drive(1'b1, 3'b000, 3'b000, 32'h0000_0055, 5'd9, 5'd9, 5'd3);
      #3;
      expect_val("mid_bypass", 32'h0000_0055); chk(o_rdata1);
      #1;
      rst_n = 1'b0;
      #1;
      expect_val("mid_rst_bypass_off", 32'h0); chk(o_rdata1);
      expect_val("mid_rst_x3_cleared", 32'h0); chk(o_rdata2);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1'b0, 3'b000, 3'b000, 32'h0, 5'd0, 5'd9, 5'd15);
      #3;
      expect_val("mid_rst_x9_lost", 32'h0);    chk(o_rdata1);
      expect_val("mid_rst_x15_cleared", 32'h0); chk(o_rdata2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
